// File: rtl/obj_scheduler_pkg.sv
// Shared definitions for the on-screen object scheduler: descriptor layout,
// slot count, sweep FSM states and a valid-bit population count.
package obj_pkg;

  localparam int FRAME_MSB = 25;
  localparam int TYPE_MSB  = 22;
  localparam int X_MSB     = 20;
  localparam int Y_MSB     = 9;

  localparam int FRAME_LSB = TYPE_MSB + 1;
  localparam int TYPE_LSB  = X_MSB + 1;
  localparam int X_LSB     = Y_MSB + 1;

  localparam int FRAME_W = FRAME_MSB - TYPE_MSB;
  localparam int TYPE_W  = TYPE_MSB - X_MSB;
  localparam int X_W     = X_MSB - Y_MSB;
  localparam int Y_W     = Y_MSB + 1;
  localparam int DESC_W  = FRAME_MSB + 1;

  localparam int NUM_OBJ = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  function automatic logic [IDX_W-1:0] count_valid(input logic [NUM_OBJ-1:0] v);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      n = n + {{(IDX_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/obj_scheduler_if.sv
// Spawn request/acknowledge handshake between the game logic (master) and
// the object scheduler (slave).
interface obj_scheduler_if;
  import obj_pkg::*;

  logic              spawn_req;
  logic [TYPE_W-1:0] spawn_type;
  logic [Y_W-1:0]    spawn_y;
  logic              spawn_ack;

  modport master (output spawn_req, output spawn_type, output spawn_y, input spawn_ack);
  modport slave  (input spawn_req, input spawn_type, input spawn_y, output spawn_ack);

endinterface

// File: rtl/obj_scheduler_slot_alloc.sv
// Lowest-index free slot priority encoder used to place new spawns.
module obj_slot_alloc
  import obj_pkg::*;
(
  input  logic [NUM_OBJ-1:0] free_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_free_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx_o      = '0;
    any_free_o = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o      = IDX_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obj_scheduler.sv
// Owns the five object slots: spawns into the lowest free slot, sweeps every
// slot once per frame (scroll, retire, animate). Animation: OBJ_SCHED_ANIM_EN.
module obj_scheduler
  import obj_pkg::*;
#(
  parameter int SPAWN_X      = 1023,
  parameter int ANIM_DIV_LOG = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync,
  input  logic [X_W-1:0]      scroll,
  obj_scheduler_if.slave      spawn,
  input  logic [NUM_OBJ-1:0]  clear_mask,
  output logic [DESC_W-1:0]   obj1,
  output logic [DESC_W-1:0]   obj2,
  output logic [DESC_W-1:0]   obj3,
  output logic [DESC_W-1:0]   obj4,
  output logic [DESC_W-1:0]   obj5,
  output logic                busy,
  output logic                frame_done,
  output logic [IDX_W-1:0]    active_count
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                prev_vsync_q;
  logic [NUM_OBJ-1:0]  valid_q, valid_d;
  logic [DESC_W-1:0]   desc_q [NUM_OBJ];
  logic [DESC_W-1:0]   desc_d [NUM_OBJ];
  logic                ack_q, ack_d;
  logic [IDX_W-1:0]    count_q, count_d;

  logic                frame_start;
  logic                anim_tick;
  logic [NUM_OBJ-1:0]  free_slots;
  logic [IDX_W-1:0]    alloc_idx;
  logic                any_free;
  logic [DESC_W-1:0]   spawn_desc;

  assign frame_start = prev_vsync_q & ~vsync;
  // A slot being cleared this cycle is not offered, so spawn and clear never collide.
  assign free_slots  = ~valid_q & ~clear_mask;
  assign spawn_desc  = {FRAME_W'(0), spawn.spawn_type, X_W'(SPAWN_X), spawn.spawn_y};

  obj_slot_alloc u_alloc (
    .free_i     (free_slots),
    .idx_o      (alloc_idx),
    .any_free_o (any_free)
  );

`ifdef OBJ_SCHED_ANIM_EN
  logic [ANIM_DIV_LOG-1:0] frame_cnt_q;

  // Global frame counter; the sweep sees the already-incremented value.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (state_q == IDLE && frame_start) begin
      frame_cnt_q <= frame_cnt_q + ANIM_DIV_LOG'(1);
    end
  end

  assign anim_tick = (frame_cnt_q == '0);
`else
  logic unused_anim_div;
  assign unused_anim_div = |ANIM_DIV_LOG;
  assign anim_tick       = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      prev_vsync_q <= 1'b0;
      valid_q      <= '0;
      ack_q        <= 1'b0;
      count_q      <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        desc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prev_vsync_q <= vsync;
      valid_q      <= valid_d;
      ack_q        <= ack_d;
      count_q      <= count_d;
      for (int i = 0; i < NUM_OBJ; i++) begin
        desc_q[i] <= desc_d[i];
      end
    end
  end

  // Next-state and slot update; clears are applied last so they win over sweep.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    desc_d  = desc_q;
    ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SWEEP;
          idx_d   = '0;
        end else if (spawn.spawn_req && any_free) begin
          for (int i = 0; i < NUM_OBJ; i++) begin
            if (alloc_idx == IDX_W'(i)) begin
              valid_d[i] = 1'b1;
              desc_d[i]  = spawn_desc;
            end
          end
          ack_d = 1'b1;
        end
      end
      SWEEP: begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (idx_q == IDX_W'(i) && valid_q[i]) begin
            if (desc_q[i][X_MSB:X_LSB] < scroll) begin
              valid_d[i] = 1'b0;
              desc_d[i]  = '0;
            end else begin
              desc_d[i][X_MSB:X_LSB] = desc_q[i][X_MSB:X_LSB] - scroll;
              if (anim_tick) begin
                desc_d[i][FRAME_MSB:FRAME_LSB] = desc_q[i][FRAME_MSB:FRAME_LSB] + FRAME_W'(1);
              end
            end
          end
        end
        if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    for (int i = 0; i < NUM_OBJ; i++) begin
      if (clear_mask[i]) begin
        valid_d[i] = 1'b0;
        desc_d[i]  = '0;
      end
    end

    count_d = count_valid(valid_d);
  end

  assign obj1            = desc_q[0];
  assign obj2            = desc_q[1];
  assign obj3            = desc_q[2];
  assign obj4            = desc_q[3];
  assign obj5            = desc_q[4];
  assign busy            = (state_q == SWEEP);
  assign frame_done      = (state_q == DONE);
  assign active_count    = count_q;
  assign spawn.spawn_ack = ack_q;

endmodule

// File: tb/tb_obj_scheduler.sv
// Directed testbench for obj_scheduler: a per-cycle spawn/clear vector table
// followed by hand-written multi-cycle frame sweep sequences.
module tb_obj_scheduler;
  import obj_pkg::*;

`ifdef OBJ_SCHED_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              vsync;
  logic [X_W-1:0]    scroll;
  logic [NUM_OBJ-1:0] clear_mask;
  logic [DESC_W-1:0] obj1, obj2, obj3, obj4, obj5;
  logic              busy;
  logic              frame_done;
  logic [IDX_W-1:0]  active_count;

  int checks = 0;
  int errors = 0;

  obj_scheduler_if sif ();

  obj_scheduler #(.SPAWN_X(1023), .ANIM_DIV_LOG(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .vsync        (vsync),
    .scroll       (scroll),
    .spawn        (sif.slave),
    .clear_mask   (clear_mask),
    .obj1         (obj1),
    .obj2         (obj2),
    .obj3         (obj3),
    .obj4         (obj4),
    .obj5         (obj5),
    .busy         (busy),
    .frame_done   (frame_done),
    .active_count (active_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic               req;
    logic [1:0]         typ;
    logic [9:0]         y;
    logic [NUM_OBJ-1:0] clr;
    logic               expAck;
    logic [2:0]         expCnt;
    logic [4:0][25:0]   expObj;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [25:0] mk(input int f, input int t, input int x, input int y);
    return {3'(f), 2'(t), 11'(x), 10'(y)};
  endfunction

  task automatic addVec(input logic req, input int typ, input int y, input logic [4:0] clr,
                        input logic ack, input int cnt,
                        input logic [25:0] o1, input logic [25:0] o2, input logic [25:0] o3,
                        input logic [25:0] o4, input logic [25:0] o5);
    vec_t v;
    v.req    = req;
    v.typ    = 2'(typ);
    v.y      = 10'(y);
    v.clr    = clr;
    v.expAck = ack;
    v.expCnt = 3'(cnt);
    v.expObj = {o5, o4, o3, o2, o1};
    vecs.push_back(v);
  endtask

  // Advance one clock and sample one time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sif.spawn_req  = v.req;
    sif.spawn_type = v.typ;
    sif.spawn_y    = v.y;
    clear_mask     = v.clr;
  endtask

  task automatic checkObjs(input string tag, input logic [4:0][25:0] exp);
    checkOutput({tag, ".obj1"}, 32'(obj1), 32'(exp[0]));
    checkOutput({tag, ".obj2"}, 32'(obj2), 32'(exp[1]));
    checkOutput({tag, ".obj3"}, 32'(obj3), 32'(exp[2]));
    checkOutput({tag, ".obj4"}, 32'(obj4), 32'(exp[3]));
    checkOutput({tag, ".obj5"}, 32'(obj5), 32'(exp[4]));
  endtask

  task automatic spawnObj(input string tag, input int typ, input int y);
    bit acked;
    acked = 1'b0;
    sif.spawn_req  = 1'b1;
    sif.spawn_type = 2'(typ);
    sif.spawn_y    = 10'(y);
    for (int c = 0; c < 10 && !acked; c++) begin
      tick();
      if (sif.spawn_ack) acked = 1'b1;
    end
    sif.spawn_req = 1'b0;
    checkOutput({tag, ".ack"}, 32'(acked), 32'd1);
  endtask

  task automatic runFrame(output int busyCycles, output bit gotDone);
    busyCycles = 0;
    gotDone    = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int c = 0; c < 20 && !gotDone; c++) begin
      tick();
      if (busy) busyCycles++;
      if (frame_done) gotDone = 1'b1;
    end
  endtask

  task automatic checkedFrame(input string tag);
    int  bc;
    bit  gd;
    runFrame(bc, gd);
    checkOutput({tag, ".frame_done"}, 32'(gd), 32'd1);
    checkOutput({tag, ".busy_cycles"}, 32'(bc), 32'd5);
  endtask

  initial begin
    logic [25:0] A, B, C, D, E, F, G, Z;
    int bc, doneAt, ackAt, donePulses;
    bit gd, ackInSweep;

    A = mk(0, 1, 1023, 300);
    B = mk(0, 2, 1023, 100);
    C = mk(0, 3, 1023, 200);
    D = mk(0, 0, 1023, 50);
    E = mk(0, 1, 1023, 400);
    F = mk(0, 2, 1023, 500);
    G = mk(0, 3, 1023, 7);
    Z = '0;

    addVec(1, 1, 300, 5'b00000, 1, 1, A, Z, Z, Z, Z);
    addVec(1, 2, 100, 5'b00000, 1, 2, A, B, Z, Z, Z);
    addVec(1, 3, 200, 5'b00000, 1, 3, A, B, C, Z, Z);
    addVec(1, 0,  50, 5'b00000, 1, 4, A, B, C, D, Z);
    addVec(1, 1, 400, 5'b00000, 1, 5, A, B, C, D, E);
    addVec(1, 2, 500, 5'b00000, 0, 5, A, B, C, D, E);
    addVec(1, 2, 500, 5'b00100, 0, 4, A, B, Z, D, E);
    addVec(1, 2, 500, 5'b00000, 1, 5, A, B, F, D, E);
    addVec(0, 0,   0, 5'b10001, 0, 3, Z, B, F, D, Z);
    addVec(0, 0,   0, 5'b00001, 0, 3, Z, B, F, D, Z);
    addVec(1, 3,   7, 5'b00000, 1, 4, G, B, F, D, Z);
    addVec(0, 0,   0, 5'b11111, 0, 0, Z, Z, Z, Z, Z);

    reset          = 1'b1;
    vsync          = 1'b0;
    scroll         = '0;
    clear_mask     = '0;
    sif.spawn_req  = 1'b0;
    sif.spawn_type = '0;
    sif.spawn_y    = '0;
    tick();
    tick();
    reset = 1'b0;

    checkObjs("reset", {Z, Z, Z, Z, Z});
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset.ack", 32'(sif.spawn_ack), 32'd0);
    checkOutput("reset.count", 32'(active_count), 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d.ack", i), 32'(sif.spawn_ack), 32'(vecs[i].expAck));
      checkOutput($sformatf("v%0d.count", i), 32'(active_count), 32'(vecs[i].expCnt));
      checkObjs($sformatf("v%0d", i), vecs[i].expObj);
    end
    sif.spawn_req = 1'b0;
    clear_mask    = '0;

    $display("[TB] scroll and retire");
    spawnObj("scroll.spawn", 1, 300);
    scroll = 11'd1000;
    checkedFrame("scroll.f1");
    checkOutput("scroll.f1.obj1", 32'(obj1), 32'(mk(0, 1, 23, 300)));
    checkOutput("scroll.f1.count", 32'(active_count), 32'd1);
    checkedFrame("scroll.f2");
    checkOutput("scroll.f2.obj1", 32'(obj1), 32'd0);
    checkOutput("scroll.f2.count", 32'(active_count), 32'd0);

    $display("[TB] x equal to scroll boundary");
    spawnObj("edge.spawn", 0, 77);
    scroll = 11'd983;
    checkedFrame("edge.f1");
    checkOutput("edge.f1.obj1", 32'(obj1), 32'(mk(0, 0, 40, 77)));
    scroll = 11'd40;
    checkedFrame("edge.f2");
    checkOutput("edge.f2.obj1", 32'(obj1), 32'(mk(0, 0, 0, 77)));
    checkOutput("edge.f2.count", 32'(active_count), 32'd1);
    scroll = 11'd1;
    checkedFrame("edge.f3");
    checkOutput("edge.f3.obj1", 32'(obj1), 32'd0);
    checkOutput("edge.f3.count", 32'(active_count), 32'd0);

    $display("[TB] spawn on frame start is deferred");
    scroll = '0;
    vsync = 1'b1;
    tick();
    vsync          = 1'b0;
    sif.spawn_req  = 1'b1;
    sif.spawn_type = 2'd2;
    sif.spawn_y    = 10'd123;
    ackInSweep = 1'b0;
    doneAt     = -1;
    ackAt      = -1;
    for (int c = 0; c < 20 && ackAt < 0; c++) begin
      tick();
      if (sif.spawn_ack && (busy || frame_done)) ackInSweep = 1'b1;
      if (frame_done) doneAt = c;
      if (sif.spawn_ack) ackAt = c;
    end
    sif.spawn_req = 1'b0;
    checkOutput("defer.ack_in_sweep", 32'(ackInSweep), 32'd0);
    checkOutput("defer.done_cycle", 32'(doneAt), 32'd5);
    checkOutput("defer.ack_cycle", 32'(ackAt), 32'd7);
    checkOutput("defer.obj1", 32'(obj1), 32'(mk(0, 2, 1023, 123)));

    $display("[TB] animation over 16 frames");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spawnObj("anim.spawn", 1, 5);
    for (int k = 1; k <= 16; k++) begin
      runFrame(bc, gd);
      if (k == 7 || k == 8 || k == 16) begin
        checkOutput($sformatf("anim.f%0d.obj1", k), 32'(obj1),
                    32'(mk(ANIM ? k / 8 : 0, 1, 1023, 5)));
      end
    end

    $display("[TB] reset during sweep");
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midreset.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    checkObjs("midreset", {Z, Z, Z, Z, Z});
    checkOutput("midreset.busy", 32'(busy), 32'd0);
    checkOutput("midreset.count", 32'(active_count), 32'd0);
    reset = 1'b0;
    donePulses = 0;
    if (frame_done) donePulses++;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (frame_done) donePulses++;
    end
    checkOutput("midreset.frame_done_pulses", 32'(donePulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
